stopwatch_ctrl: RTL and testbench

- Sequencing controller for the team's 16-bit seconds counter.
- Conditions two raw push-buttons (start/stop, lap/clear) into one-cycle press pulses.
- Generates the counter's enable, clear and 1 Hz tick, and holds a lap snapshot for the display path.
- Sits between board buttons and the counter/7-seg display; the counter consumes CNT_EN, CNT_CLR and TICK.

---
 rtl/stopwatch_pkg.sv | 23 ++
 rtl/btn_debounce.sv | 52 +++++
 rtl/stopwatch_ctrl.sv | 126 ++++++++++++
 tb/tb_stopwatch_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | stopwatch_pkg : shared state encoding and board defaults        |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
package stopwatch_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_t;

  // 100 MHz board: 10 ms debounce window, 1 Hz tick
  localparam int DEF_DEB_CYCLES = 1_000_000;
  localparam int DEF_TICK_FULL  = 100_000_000;
  localparam int DEF_VAL_W      = 16;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | btn_debounce : 2-flop sync, debounce counter, press pulse       |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      pulse   <= 1'b0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_d <= level;
      pulse   <= level & ~level_d;
      // Level follows only after DEB_CYCLES consecutive disagreeing samples
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | stopwatch_ctrl : button-driven run/pause/lap sequencer, 1 Hz tick|
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int TICK_FULL  = DEF_TICK_FULL,
  parameter int VAL_W      = DEF_VAL_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               BTN_SS,
  input  logic               BTN_LC,
  input  logic [VAL_W-1:0]   VAL,
  output logic               CNT_EN,
  output logic               CNT_CLR,
  output logic               TICK,
  output logic [VAL_W-1:0]   DISP,
  output logic [STATE_W-1:0] STATE
);

  localparam logic [31:0] PRESC_LAST = 32'(TICK_FULL - 1);

  logic ss_pulse;
  logic lc_pulse;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ss (
    .clk   (CLK),
    .rst   (RST),
    .btn   (BTN_SS),
    .pulse (ss_pulse)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lc (
    .clk   (CLK),
    .rst   (RST),
    .btn   (BTN_LC),
    .pulse (lc_pulse)
  );

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      presc;
  logic [31:0]      presc_nxt;
  logic [VAL_W-1:0] lap;
  logic             presc_clr;
  logic             lap_load;
  logic             clr_nxt;
  logic             tick_nxt;
  logic             running;

  // Start/stop has priority: LC is only considered when SS is absent
  always_comb begin
    state_nxt = state;
    clr_nxt   = 1'b0;
    presc_clr = 1'b0;
    lap_load  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ss_pulse) begin
          state_nxt = ST_RUN;
          presc_clr = 1'b1;
        end else if (lc_pulse) begin
          clr_nxt = 1'b1;
        end
      end
      ST_RUN: begin
        if (ss_pulse) begin
          state_nxt = ST_PAUSE;
        end else if (lc_pulse) begin
          state_nxt = ST_LAP;
          lap_load  = 1'b1;
        end
      end
      ST_LAP: begin
        if (ss_pulse)      state_nxt = ST_PAUSE;
        else if (lc_pulse) state_nxt = ST_RUN;
      end
      ST_PAUSE: begin
        if (ss_pulse) begin
          state_nxt = ST_RUN;
        end else if (lc_pulse) begin
          state_nxt = ST_IDLE;
          clr_nxt   = 1'b1;
          presc_clr = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    running  = (state == ST_RUN) || (state == ST_LAP);
    tick_nxt = running && (presc == PRESC_LAST);
    if (presc_clr)     presc_nxt = '0;
    else if (tick_nxt) presc_nxt = '0;
    else if (running)  presc_nxt = presc + 32'd1;
    else               presc_nxt = presc;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= ST_IDLE;
      presc   <= '0;
      lap     <= '0;
      CNT_EN  <= 1'b0;
      CNT_CLR <= 1'b0;
      TICK    <= 1'b0;
      DISP    <= '0;
    end else begin
      state   <= state_nxt;
      presc   <= presc_nxt;
      CNT_EN  <= (state_nxt == ST_RUN) || (state_nxt == ST_LAP);
      CNT_CLR <= clr_nxt;
      TICK    <= tick_nxt;
      if (lap_load) lap <= VAL;
      // On lap entry the snapshot is VAL itself, so live VAL is shown that cycle
      DISP    <= ((state_nxt == ST_LAP) && !lap_load) ? lap : VAL;
    end
  end

  assign STATE = state;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_stopwatch_ctrl : scoreboard bench for stopwatch_ctrl         |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_stopwatch_ctrl;

  localparam int HOLD = 12;

  logic        clk    = 1'b0;
  logic        rst    = 1'b0;
  logic        btn_ss = 1'b0;
  logic        btn_lc = 1'b0;
  logic [15:0] val    = 16'h0000;
  logic        probe  = 1'b0;
  int          probe_kind = 0;

  logic        cnt_en;
  logic        cnt_clr;
  logic        tick;
  logic [15:0] disp;
  logic [1:0]  state;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;
  int b;

  typedef struct {
    int cyc;
    int val;
  } exp_t;

  exp_t st_q[$];
  exp_t tick_q[$];
  exp_t clr_q[$];
  exp_t disp_q[$];
  logic [1:0] prev_state = 2'd0;

  stopwatch_ctrl #(
    .DEB_CYCLES (4),
    .TICK_FULL  (10),
    .VAL_W      (16)
  ) dut (
    .CLK     (clk),
    .RST     (rst),
    .BTN_SS  (btn_ss),
    .BTN_LC  (btn_lc),
    .VAL     (val),
    .CNT_EN  (cnt_en),
    .CNT_CLR (cnt_clr),
    .TICK    (tick),
    .DISP    (disp),
    .STATE   (state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input int act);
    checks++;
    failures++;
    $display("FAIL %s: got unexpected value %0d expected no event (cycle %0d)", name, act, cyc);
  endtask

  function automatic void exp_state(input int c, input int v);
    st_q.push_back('{cyc: c, val: v});
  endfunction
  function automatic void exp_tick(input int c);
    tick_q.push_back('{cyc: c, val: 1});
  endfunction
  function automatic void exp_clr(input int c);
    clr_q.push_back('{cyc: c, val: 1});
  endfunction
  function automatic void exp_disp(input int c, input int v);
    disp_q.push_back('{cyc: c, val: v});
  endfunction

  // Monitor: pops the scoreboard whenever the DUT shows an event
  always @(negedge clk or posedge probe) begin
    exp_t e;
    if (probe) begin
      if (probe_kind == 1) begin
        cmp("rst_state",   int'(state),   0);
        cmp("rst_cnt_en",  int'(cnt_en),  0);
        cmp("rst_cnt_clr", int'(cnt_clr), 0);
        cmp("rst_tick",    int'(tick),    0);
        cmp("rst_disp",    int'(disp),    0);
      end else begin
        cmp("final_state",   int'(state), 0);
        cmp("state_pending", st_q.size(),   0);
        cmp("tick_pending",  tick_q.size(), 0);
        cmp("clr_pending",   clr_q.size(),  0);
        cmp("disp_pending",  disp_q.size(), 0);
      end
    end else if (rst) begin
      prev_state <= state;
    end else begin
      if (state != prev_state) begin
        if (st_q.size() == 0) begin
          unexpected("state_change", int'({cnt_en, state}));
        end else begin
          e = st_q.pop_front();
          cmp("state_cycle", cyc, e.cyc);
          cmp("state_en_value", int'({cnt_en, state}), e.val);
        end
      end
      if (tick) begin
        if (tick_q.size() == 0) begin
          unexpected("tick", 1);
        end else begin
          e = tick_q.pop_front();
          cmp("tick_cycle", cyc, e.cyc);
        end
      end
      if (cnt_clr) begin
        if (clr_q.size() == 0) begin
          unexpected("cnt_clr", 1);
        end else begin
          e = clr_q.pop_front();
          cmp("clr_cycle", cyc, e.cyc);
          cmp("clr_exclusive", int'(cnt_en | tick), 0);
        end
      end
      if (disp_q.size() != 0 && disp_q[0].cyc == cyc) begin
        e = disp_q.pop_front();
        cmp("disp", int'(disp), e.val);
      end
      prev_state <= state;
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic press(input int at, input logic ss, input logic lc);
    wait_cyc(at);
    if (ss) begin
      btn_ss = 1'b1;
      fork
        begin
          repeat (HOLD) @(negedge clk);
          btn_ss = 1'b0;
        end
      join_none
    end
    if (lc) begin
      btn_lc = 1'b1;
      fork
        begin
          repeat (HOLD) @(negedge clk);
          btn_lc = 1'b0;
        end
      join_none
    end
  endtask

  // Press at cycle p: pulse after edge p+7, state change visible at p+8
  initial begin
    #1 rst = 1'b1;
    #1 probe_kind = 1; probe = 1'b1;
    #1 probe = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    b = cyc + 5;

    exp_state(b + 8, 5);
    for (int k = 0; k < 10; k++) exp_tick(b + 18 + 10 * k);
    press(b, 1'b1, 1'b0);

    wait_cyc(b + 30);
    val = 16'h0012;
    exp_state(b + 49, 7);
    exp_disp(b + 50, 16'h0012);
    exp_disp(b + 53, 16'h0012);
    exp_disp(b + 60, 16'h0012);
    press(b + 41, 1'b0, 1'b1);
    wait_cyc(b + 50); val = 16'h0013;
    wait_cyc(b + 51); val = 16'h0014;
    wait_cyc(b + 52); val = 16'h0015;

    exp_state(b + 79, 5);
    exp_disp(b + 82, 16'h0015);
    exp_disp(b + 83, 16'h0020);
    press(b + 71, 1'b0, 1'b1);
    wait_cyc(b + 82); val = 16'h0020;

    exp_state(b + 113, 2);
    press(b + 105, 1'b1, 1'b0);

    exp_state(b + 173, 5);
    exp_tick(b + 178);
    exp_tick(b + 188);
    press(b + 165, 1'b1, 1'b0);

    exp_state(b + 193, 2);
    press(b + 185, 1'b1, 1'b0);

    exp_state(b + 218, 0);
    exp_clr(b + 218);
    press(b + 210, 1'b0, 1'b1);

    exp_clr(b + 248);
    exp_disp(b + 255, 16'h0020);
    exp_disp(b + 256, 16'h0033);
    press(b + 240, 1'b0, 1'b1);
    wait_cyc(b + 255); val = 16'h0033;

    exp_state(b + 278, 5);
    exp_tick(b + 288);
    exp_tick(b + 298);
    press(b + 270, 1'b1, 1'b1);

    wait_cyc(b + 300);
    #2 rst = 1'b1;
    #1 probe_kind = 1; probe = 1'b1;
    #1 probe = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    repeat (5) begin
      btn_ss = 1'b1;
      repeat (3) @(negedge clk);
      btn_ss = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (20) @(negedge clk);

    #3 probe_kind = 2; probe = 1'b1;
    #1 probe = 1'b0;
    #1 $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
